// File: rtl/gpia_input_port.sv
// Purpose: GPIA-III input side; synchronises pins into clk_i, latches any-edge change flags, serves Wishbone reads.
// Latency: pin change in s1 sets its flag two edges later; ack_o and dat_o are registered, one cycle after the request.
// Backpressure: none; every request is acked once and a single idle cycle separates back-to-back acks.
//
// Ports:
//   clk_i, res_i          clock, asynchronous active-high reset
//   pins_i                external pins, asynchronous to clk_i
//   cyc_i, stb_i, we_i    Wishbone cycle / strobe / write enable
//   adr_i                 register select: 0 PIN, 1 EDGE (W1C), 2 IE, 3 reserved
//   dat_i, dat_o          write data / registered read data
//   ack_o                 registered acknowledge
//   irq_o                 registered interrupt request (only with GPIA_IRQ_EN)
// Build option: define GPIA_IRQ_EN to add the IE register and irq_o; without it adr 2 is reserved.

module gpia_input_port #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic [WIDTH-1:0] pins_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [1:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
`ifdef GPIA_IRQ_EN
    output logic             ack_o,
    output logic             irq_o
`else
    output logic             ack_o
`endif
);

    logic [WIDTH-1:0] s1, s2, s3;
    logic [WIDTH-1:0] flags, flags_nxt;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_val;
    logic [1:0]       wu;
    logic             req;
    logic             wr;

    // A request is serviced on the edge that raises ack_o; the ~ack_o term
    // both forces the idle cycle between acks and prevents a double service.
    assign req = cyc_i & stb_i & ~ack_o;
    assign wr  = req & we_i;
    assign clr = (wr && adr_i == 2'd1) ? dat_i : '0;

`ifdef GPIA_IRQ_EN
    logic [WIDTH-1:0] ie, ie_nxt;

    always_comb begin
        ie_nxt = ie;
        if (wr && adr_i == 2'd2)
            ie_nxt = dat_i;
    end
`endif

    // Set is OR-ed in after the clear so a simultaneous edge keeps the bit set.
    // Flags hold during warm-up so the reset-to-pin transition through the
    // synchroniser is not mistaken for a real edge.
    always_comb begin
        flags_nxt = flags;
        if (wu == 2'd3)
            flags_nxt = (flags & ~clr) | (s2 ^ s3);
    end

    always_comb begin
        rd_val = '0;
        case (adr_i)
            2'd0:    rd_val = s2;
            2'd1:    rd_val = flags;
`ifdef GPIA_IRQ_EN
            2'd2:    rd_val = ie;
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            flags <= '0;
            wu    <= 2'd0;
            dat_o <= '0;
            ack_o <= 1'b0;
        end else begin
            s1    <= pins_i;
            s2    <= s1;
            s3    <= s2;
            flags <= flags_nxt;
            if (wu != 2'd3)
                wu <= wu + 2'd1;
            ack_o <= req;
            // Loaded on every serviced request; value is meaningless on writes.
            if (req)
                dat_o <= rd_val;
        end
    end

`ifdef GPIA_IRQ_EN
    // Uses post-update flags/ie so a W1C of the last enabled flag drops
    // irq_o on the same edge the flag clears.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            ie    <= '0;
            irq_o <= 1'b0;
        end else begin
            ie    <= ie_nxt;
            irq_o <= |(flags_nxt & ie_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_gpia_input_port.sv
module tb_gpia_input_port;

    logic        clk_i = 1'b0;
    logic        res_i;
    logic [15:0] pins_i;
    logic        cyc_i, stb_i, we_i;
    logic [1:0]  adr_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack_o;
`ifdef GPIA_IRQ_EN
    logic        irq_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    gpia_input_port #(.WIDTH(16)) dut (
        .clk_i  (clk_i),
        .res_i  (res_i),
        .pins_i (pins_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
`ifdef GPIA_IRQ_EN
        .ack_o  (ack_o),
        .irq_o  (irq_o)
`else
        .ack_o  (ack_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wb_write(input string tag, input logic [1:0] a, input logic [15:0] d);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
        tick(1);
        check({tag, "_ack"}, 16'(ack_o), 16'h0001);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
        tick(1);
    endtask

    task automatic wb_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a;
        tick(1);
        check({tag, "_ack"}, 16'(ack_o), 16'h0001);
        check(tag, dat_o, exp);
        cyc_i = 1'b0; stb_i = 1'b0;
        tick(1);
    endtask

    logic [15:0] ack_seen;

    initial begin
        res_i = 1'b1; pins_i = 16'hFFFF;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = '0;

        // 1: reset state, then warm-up hides the 0->FFFF synchroniser transition
        tick(3);
        check("rst_ack", 16'(ack_o), 16'h0000);
        check("rst_dat", dat_o, 16'h0000);
`ifdef GPIA_IRQ_EN
        check("rst_irq", 16'(irq_o), 16'h0000);
`endif
        res_i = 1'b0;
        tick(10);
        wb_read("t1_pin", 2'd0, 16'hFFFF);
        wb_read("t1_edge", 2'd1, 16'h0000);

        // 2: single-clock pulse on bit 3 gets latched
        pins_i = 16'h0000;
        tick(5);
        wb_write("t2_clrall", 2'd1, 16'hFFFF);
        wb_read("t2_edge0", 2'd1, 16'h0000);
        pins_i[3] = 1'b1;
        tick(1);
        pins_i[3] = 1'b0;
        tick(5);
        wb_read("t2_pin", 2'd0, 16'h0000);
        wb_read("t2_edge", 2'd1, 16'h0008);

        // 3: clear collides with a new bit-3 edge; set must win
        pins_i[3] = 1'b1;
        tick(2);                 // s2 just took the new value, s3 still old
        wb_write("t3_w1", 2'd1, 16'h0008);
        wb_read("t3_setwins", 2'd1, 16'h0008);
        wb_write("t3_w2", 2'd1, 16'h0008);
        wb_read("t3_cleared", 2'd1, 16'h0000);

        // PIN and reserved registers ignore writes
        wb_write("ro_pin_w", 2'd0, 16'h0000);
        wb_read("ro_pin", 2'd0, 16'h0008);
        wb_write("rsvd_w", 2'd3, 16'hABCD);
        wb_read("rsvd", 2'd3, 16'h0000);
        wb_write("ie_w", 2'd2, 16'h1234);
`ifdef GPIA_IRQ_EN
        wb_read("ie_rd", 2'd2, 16'h1234);
        wb_write("ie_zero", 2'd2, 16'h0000);
`else
        wb_read("ie_rd", 2'd2, 16'h0000);
`endif

        // 4: held request acks every other cycle
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd0;
        ack_seen = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            ack_seen[i] = ack_o;
            if (i < 5) begin
                @(posedge clk_i);
                #1;
            end
        end
        check("t4_ackpat", ack_seen, 16'b101010);
        cyc_i = 1'b0; stb_i = 1'b0;
        tick(2);

        // cancelled write: strobe withdrawn before the edge
        pins_i[3] = 1'b0;
        tick(5);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 2'd1; dat_i = 16'hFFFF;
        #4;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
        tick(1);
        check("t4_noack", 16'(ack_o), 16'h0000);
        wb_read("t4_nochange", 2'd1, 16'h0008);

        // 6: async reset during an acked request with EDGE = 00FF
        pins_i = 16'h00FF;
        tick(5);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd1;
        tick(1);
        check("t6_pre_ack", 16'(ack_o), 16'h0001);
        check("t6_pre_dat", dat_o, 16'h00FF);
        #2;
        res_i = 1'b1;
        #1;
        check("t6_rst_ack", 16'(ack_o), 16'h0000);
        check("t6_rst_dat", dat_o, 16'h0000);
`ifdef GPIA_IRQ_EN
        check("t6_rst_irq", 16'(irq_o), 16'h0000);
`endif
        cyc_i = 1'b0; stb_i = 1'b0;
        tick(2);
        res_i = 1'b0;
        tick(10);
        wb_read("t6_edge", 2'd1, 16'h0000);
        wb_read("t6_pin", 2'd0, 16'h00FF);

`ifdef GPIA_IRQ_EN
        // 5: interrupt path
        wb_write("t5_ie", 2'd2, 16'h0010);
        pins_i[4] = 1'b0;
        begin
            logic got_irq;
            got_irq = 1'b0;
            for (int i = 0; i < 4 && !got_irq; i++) begin
                tick(1);
                got_irq = irq_o;
            end
            check("t5_irq_set", 16'(got_irq), 16'h0001);
        end
        tick(2);
        wb_write("t5_clr", 2'd1, 16'h0010);
        check("t5_irq_clr", 16'(irq_o), 16'h0000);
        pins_i[5] = 1'b0;
        tick(6);
        check("t5_irq_masked", 16'(irq_o), 16'h0000);
        wb_read("t5_edge5", 2'd1, 16'h0020);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
